// File: rtl/pwm_capture_pkg.sv
// rtl/pwm_capture_pkg.sv - shared FSM encoding and default sizing for the PWM capture block
package pwm_capture_pkg;

   localparam int N_DEFAULT       = 19;
   localparam int TIMEOUT_DEFAULT = 500_000;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_MEAS_HIGH = 2'd1,
      ST_MEAS_LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - pulse input and measurement result bundle
interface pwm_capture_if
   import pwm_capture_pkg::*;
#(
   parameter int N = N_DEFAULT
);

   logic         pwm_in;
   logic [N-1:0] high_width;
   logic [N-1:0] period;
   logic         valid;
   logic         timeout;
   logic         level;

   // master drives the pulse train and observes results; slave is the capture block
   modport master (
      output pwm_in,
      input  high_width, period, valid, timeout, level
   );

   modport slave (
      input  pwm_in,
      output high_width, period, valid, timeout, level
   );

endinterface

// File: rtl/pwm_capture_edge_sync.sv
// rtl/pwm_capture_edge_sync.sv - 2-flop synchronizer with registered rise/fall detection
module pwm_capture_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s,
   output logic rise,
   output logic fall
);

   logic       s1;
   logic       s_d;
   logic [1:0] fill;
   logic       armed;

   // Edges are only reported once s has been seen low with a filled synchronizer,
   // so a pulse already high at reset release is never mistaken for a rise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1    <= 1'b0;
         s     <= 1'b0;
         s_d   <= 1'b0;
         fill  <= 2'b00;
         armed <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         s1   <= d;
         s    <= s1;
         s_d  <= s;
         fill <= {fill[0], 1'b1};
         if (fill == 2'b11 && !s) begin
            armed <= 1'b1;
         end
         rise <= armed & s & ~s_d;
         fall <= armed & ~s & s_d;
      end
   end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures high width and period of a pulse train, flags a stuck input
module pwm_capture
   import pwm_capture_pkg::*;
#(
   parameter int N       = N_DEFAULT,
   parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
   input logic          clk,
   input logic          rst,
   pwm_capture_if.slave bus
);

   localparam logic [N-1:0] LIMIT = N'(TIMEOUT);
   localparam logic [N-1:0] ONE   = N'(1);

   logic s_lvl;
   logic rise;
   logic fall;

   pwm_capture_edge_sync u_edge_sync (
      .clk  (clk),
      .rst  (rst),
      .d    (bus.pwm_in),
      .s    (s_lvl),
      .rise (rise),
      .fall (fall)
   );

   state_t       state_q, state_d;
   logic [N-1:0] cnt_q, cnt_d;
   logic [N-1:0] idle_q, idle_d;
   logic [N-1:0] hw_q, hw_d;
   logic [N-1:0] high_width_q, high_width_d;
   logic [N-1:0] period_q, period_d;
   logic         valid_q, valid_d;
   logic         timeout_q, timeout_d;
   logic [N-1:0] cnt_inc;

   // Saturate so the counter can never wrap even when an edge lands on the threshold.
   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         idle_q       <= '0;
         hw_q         <= '0;
         high_width_q <= '0;
         period_q     <= '0;
         valid_q      <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idle_q       <= idle_d;
         hw_q         <= hw_d;
         high_width_q <= high_width_d;
         period_q     <= period_d;
         valid_q      <= valid_d;
         timeout_q    <= timeout_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idle_d       = idle_q;
      hw_d         = hw_q;
      high_width_d = high_width_q;
      period_d     = period_q;
      valid_d      = 1'b0;
      timeout_d    = timeout_q;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (rise) begin
               state_d = ST_MEAS_HIGH;
               cnt_d   = ONE;
               idle_d  = '0;
            end else if (!timeout_q) begin
               if (idle_q >= LIMIT) begin
                  timeout_d = 1'b1;
                  idle_d    = '0;
               end else begin
                  idle_d = idle_q + ONE;
               end
            end
         end

         ST_MEAS_HIGH: begin
            if (fall) begin
               hw_d    = cnt_q;
               cnt_d   = cnt_inc;
               state_d = ST_MEAS_LOW;
            end else if (cnt_q >= LIMIT) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         ST_MEAS_LOW: begin
            // An edge arriving on the threshold cycle closes the measurement instead of timing out.
            if (rise) begin
               high_width_d = hw_q;
               period_d     = cnt_q;
               valid_d      = 1'b1;
               timeout_d    = 1'b0;
               cnt_d        = ONE;
               state_d      = ST_MEAS_HIGH;
            end else if (cnt_q >= LIMIT) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end

         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.high_width = high_width_q;
   assign bus.period     = period_q;
   assign bus.valid      = valid_q;
   assign bus.timeout    = timeout_q;
   assign bus.level      = s_lvl;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

   logic clk;
   logic rst;

   pwm_capture_if #(.N(19)) bus ();

   pwm_capture #(.N(19), .TIMEOUT(256)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nchk = 0;
   int nerr = 0;
   int cyc  = 0;

   int   nvalid, first_vcyc, first_hw, first_per, last_vcyc, last_hw, last_per, gap;
   int   to_seen, to_cyc, to_before, to_at, prev_to;
   logic prev_v;
   int   rise_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      nvalid = 0; first_vcyc = 0; first_hw = 0; first_per = 0;
      last_vcyc = 0; last_hw = 0; last_per = 0; gap = 0;
      to_seen = 0; to_cyc = 0; to_before = -1; to_at = -1;
      prev_v = bus.pwm_in;
      rise_q.delete();
   endtask

   // One clock: drive v, then sample outputs 1 time unit after the rising edge.
   task automatic step(input logic v);
      if (v && !prev_v) rise_q.push_back(cyc + 1);
      prev_v     = v;
      bus.pwm_in = v;
      prev_to    = int'(bus.timeout);
      @(posedge clk);
      #1;
      cyc++;
      if (bus.valid) begin
         if (nvalid == 0) begin
            first_vcyc = cyc;
            first_hw   = int'(bus.high_width);
            first_per  = int'(bus.period);
         end else begin
            gap = cyc - last_vcyc;
         end
         last_vcyc = cyc;
         last_hw   = int'(bus.high_width);
         last_per  = int'(bus.period);
         to_before = prev_to;
         to_at     = int'(bus.timeout);
         nvalid++;
      end
      if (bus.timeout && to_seen == 0) begin
         to_seen = 1;
         to_cyc  = cyc;
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic pattern(input int hi, input int lo, input int reps);
      for (int r = 0; r < reps; r++) begin
         hold(1'b1, hi);
         hold(1'b0, lo);
      end
   endtask

   task automatic chk_outputs_zero(input string pfx);
      chk({pfx, "_high_width"}, int'(bus.high_width), 0);
      chk({pfx, "_period"},     int'(bus.period),     0);
      chk({pfx, "_valid"},      int'(bus.valid),      0);
      chk({pfx, "_timeout"},    int'(bus.timeout),    0);
      chk({pfx, "_level"},      int'(bus.level),      0);
   endtask

   initial begin
      rst        = 1'b1;
      bus.pwm_in = 1'b0;
      clear_mon();
      hold(1'b0, 3);
      chk_outputs_zero("reset");
      rst = 1'b0;

      // 10 high / 4 low, then stuck high to provoke the timeout
      clear_mon();
      hold(1'b0, 4);
      pattern(10, 4, 4);
      hold(1'b1, 300);
      chk("p10_4_nvalid",   nvalid, 4);
      chk("p10_4_latency",  first_vcyc - rise_q[1], 3);
      chk("p10_4_first_hw", first_hw, 10);
      chk("p10_4_first_per", first_per, 14);
      chk("p10_4_gap",      gap, 14);
      chk("to_latency",     to_cyc - rise_q[4], 259);
      chk("to_level",       int'(bus.timeout), 1);
      chk("to_sync_level",  int'(bus.level), 1);
      chk("to_hw_kept",     int'(bus.high_width), 10);
      chk("to_per_kept",    int'(bus.period), 14);

      // resume 10/4 after timeout: timeout clears with the valid strobe
      clear_mon();
      hold(1'b0, 4);
      pattern(10, 4, 1);
      hold(1'b1, 5);
      chk("resume_nvalid",     nvalid, 1);
      chk("resume_to_before",  to_before, 1);
      chk("resume_to_at",      to_at, 0);
      chk("resume_hw",         last_hw, 10);
      chk("resume_per",        last_per, 14);

      // minimum pulse: 1 high / 1 low
      clear_mon();
      hold(1'b0, 3);
      pattern(1, 1, 8);
      hold(1'b0, 4);
      chk("p1_1_nvalid",    nvalid, 8);
      chk("p1_1_first_hw",  first_hw, 5);
      chk("p1_1_first_per", first_per, 8);
      chk("p1_1_hw",        last_hw, 1);
      chk("p1_1_per",       last_per, 2);
      chk("p1_1_gap",       gap, 2);

      // reset asserted during the low phase of a 20/30 pattern
      clear_mon();
      hold(1'b1, 20);
      hold(1'b0, 15);
      chk("pre_rst_hw", int'(bus.high_width), 1);
      rst = 1'b1;
      #1;
      chk_outputs_zero("midrst");
      hold(1'b0, 2);
      rst = 1'b0;
      clear_mon();
      hold(1'b0, 15);
      pattern(20, 30, 2);
      hold(1'b1, 5);
      chk("p20_30_nvalid",   nvalid, 2);
      chk("p20_30_latency",  first_vcyc - rise_q[1], 3);
      chk("p20_30_first_hw", first_hw, 20);
      chk("p20_30_first_per", first_per, 50);

      // input already high at reset release: partial pulse ignored
      rst        = 1'b1;
      bus.pwm_in = 1'b1;
      hold(1'b1, 2);
      rst = 1'b0;
      clear_mon();
      hold(1'b1, 3);
      hold(1'b0, 8);
      pattern(8, 8, 2);
      hold(1'b1, 4);
      chk("p8_8_nvalid",    nvalid, 2);
      chk("p8_8_latency",   first_vcyc - rise_q[1], 3);
      chk("p8_8_first_hw",  first_hw, 8);
      chk("p8_8_first_per", first_per, 16);

      // rise landing exactly on the timeout threshold wins
      clear_mon();
      hold(1'b0, 4);
      hold(1'b1, 250);
      hold(1'b0, 6);
      hold(1'b1, 4);
      chk("edge_win_nvalid",  nvalid, 2);
      chk("edge_win_hw",      last_hw, 250);
      chk("edge_win_per",     last_per, 256);
      chk("edge_win_no_to",   to_seen, 0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
